double_adder_initiator: RTL and testbench

Hardware initiator for the `double_adder` stb/ack interface. It accepts IEEE-754 double operand pairs on a valid/ready stream and drives `input_a`/`input_b` with independent strobes. It then collects `output_z` with a one-cycle ack and returns the sum, together with its operands, on a valid/ready result stream. It sits between a stimulus or compute source and the adder, and includes a watchdog and a transaction counter.

---
 rtl/double_adder_pkg.sv | 23 ++
 rtl/double_adder_initiator_if.sv | 33 +++
 rtl/stb_ack_watchdog.sv | 38 +++
 rtl/double_adder_initiator.sv | 151 +++++++++++++++
 tb/tb_double_adder_initiator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/double_adder_pkg.sv
// ============================================================================
// Module   : double_adder_pkg
// Brief    : Shared types for the double_adder initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package double_adder_pkg;

    localparam int DW = 64;

    typedef logic [DW-1:0] dword_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2,
        RESP   = 2'd3
    } init_state_t;

endpackage

`default_nettype wire

// File: rtl/double_adder_initiator_if.sv
// ============================================================================
// Module   : double_adder_initiator_if
// Brief    : stb/ack bus between the initiator (master) and double_adder (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface double_adder_initiator_if;
    import double_adder_pkg::*;

    dword_t input_a;
    logic   input_a_stb;
    logic   input_a_ack;
    dword_t input_b;
    logic   input_b_stb;
    logic   input_b_ack;
    dword_t output_z;
    logic   output_z_stb;
    logic   output_z_ack;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );

endinterface

`default_nettype wire

// File: rtl/stb_ack_watchdog.sv
// ============================================================================
// Module   : stb_ack_watchdog
// Brief    : 16-bit cycle counter with clear/enable; pulses o_expire on the
//            cycle whose edge brings the count to TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stb_ack_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expire
);

    localparam logic [15:0] c_last = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 16'd1;
        end
    end

    // The owner leaves the guarded state on expiry, so this is a single pulse.
    assign o_expire = i_en && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/double_adder_initiator.sv
// ============================================================================
// Module   : double_adder_initiator
// Brief    : Feeds operand pairs to double_adder over stb/ack and returns the
//            sum with its operands on a valid/ready stream; watchdog + counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module double_adder_initiator
    import double_adder_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 op_valid,
    output logic                      op_ready,
    input  wire dword_t               op_a,
    input  wire dword_t               op_b,
    double_adder_initiator_if.master  adder,
    output logic                      res_valid,
    input  wire logic                 res_ready,
    output dword_t                    res_z,
    output dword_t                    res_a,
    output dword_t                    res_b,
    output logic [CNT_W-1:0]          txn_count,
    output logic                      err_timeout,
    input  wire logic                 clr_err
);

    init_state_t        r_state;
    dword_t             r_a;
    dword_t             r_b;
    dword_t             r_z;
    logic               r_a_stb;
    logic               r_b_stb;
    logic               r_z_ack;
    logic               r_res_valid;
    logic [CNT_W-1:0]   r_txn_count;
    logic               r_err;

    logic w_accept;
    logic w_a_stb_nxt;
    logic w_b_stb_nxt;
    logic w_send_done;
    logic w_wd_en;
    logic w_expire;

    assign w_accept    = (r_state == IDLE) && op_valid;
    assign w_a_stb_nxt = r_a_stb && !adder.input_a_ack;
    assign w_b_stb_nxt = r_b_stb && !adder.input_b_ack;
    assign w_send_done = (r_state == SEND) && !w_a_stb_nxt && !w_b_stb_nxt;
    assign w_wd_en     = (r_state == SEND) || (r_state == WAIT_Z);

    stb_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept || w_send_done),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_z         <= '0;
            r_a_stb     <= 1'b0;
            r_b_stb     <= 1'b0;
            r_z_ack     <= 1'b0;
            r_res_valid <= 1'b0;
            r_txn_count <= '0;
            r_err       <= 1'b0;
        end else begin
            // A fresh timeout beats a simultaneous clear request.
            if (w_expire) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_a_stb <= 1'b1;
                        r_b_stb <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_expire) begin
                        r_a_stb <= 1'b0;
                        r_b_stb <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_a_stb <= w_a_stb_nxt;
                        r_b_stb <= w_b_stb_nxt;
                        if (!w_a_stb_nxt && !w_b_stb_nxt) begin
                            r_state <= WAIT_Z;
                        end
                    end
                end
                WAIT_Z: begin
                    if (w_expire) begin
                        r_z_ack <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_z_ack) begin
                        r_z_ack     <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (adder.output_z_stb) begin
                        r_z     <= adder.output_z;
                        r_z_ack <= 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_txn_count <= r_txn_count + CNT_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign op_ready           = (r_state == IDLE);
    assign adder.input_a      = r_a;
    assign adder.input_b      = r_b;
    assign adder.input_a_stb  = r_a_stb;
    assign adder.input_b_stb  = r_b_stb;
    assign adder.output_z_ack = r_z_ack;
    assign res_valid          = r_res_valid;
    assign res_z              = r_z;
    assign res_a              = r_a;
    assign res_b              = r_b;
    assign txn_count          = r_txn_count;
    assign err_timeout        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_double_adder_initiator.sv
// ============================================================================
// Module   : tb_double_adder_initiator
// Brief    : Randomized bench for double_adder_initiator with a cycle-level
//            adder stub and an expected-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_double_adder_initiator;

    localparam int c_timeout = 16;
    localparam int c_cnt_mod = 4;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_z;
    logic [63:0] res_a;
    logic [63:0] res_b;
    logic [1:0]  txn_count;
    logic        err_timeout;
    logic        clr_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int model_cnt = 0;

    double_adder_initiator_if ifc ();

    double_adder_initiator #(
        .TIMEOUT (c_timeout),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .adder       (ifc),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_z       (res_z),
        .res_a       (res_a),
        .res_b       (res_b),
        .txn_count   (txn_count),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_drive();
        op_valid          = 1'b0;
        op_a              = '0;
        op_b              = '0;
        res_ready         = 1'b0;
        ifc.input_a_ack   = 1'b0;
        ifc.input_b_ack   = 1'b0;
        ifc.output_z_stb  = 1'b0;
        ifc.output_z      = '0;
    endtask

    // mode 0: normal, 1: adder never acks b, 2: adder never returns z.
    // Edge 0 is the accept edge; k counts edges after it.
    task automatic run_txn(input logic [63:0] a, input logic [63:0] b,
                           input int da, input int db, input int dz,
                           input int hold, input int mode);
        int          k;
        int          s;
        int          kz;
        int          kr;
        int          kt;
        bit          done;
        logic [63:0] z;
        z    = $realtobits($bitstoreal(a) + $bitstoreal(b));
        s    = ((da > db) ? da : db) + 1;
        kz   = s + dz + 1;
        kr   = kz + 1 + hold;
        kt   = (mode == 1) ? c_timeout : s + c_timeout;
        done = 1'b0;
        @(negedge clk);
        check("op_ready_idle", 64'(op_ready), 64'(1));
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        k = 0;
        while (!done && k < 200) begin
            if (mode != 0 && k == kt) begin
                check("wd_err", 64'(err_timeout), 64'(1));
                check("wd_stb_a", 64'(ifc.input_a_stb), 64'(0));
                check("wd_stb_b", 64'(ifc.input_b_stb), 64'(0));
                check("wd_z_ack", 64'(ifc.output_z_ack), 64'(0));
                check("wd_idle", 64'(op_ready), 64'(1));
                check("wd_no_res", 64'(res_valid), 64'(0));
                done = 1'b1;
            end else if (mode != 0 || k <= kr) begin
                check("stb_a", 64'(ifc.input_a_stb), 64'(k <= da));
                check("stb_b", 64'(ifc.input_b_stb), 64'((mode == 1) || (k <= db)));
                if (k <= da) check("in_a", ifc.input_a, a);
                if (k <= db) check("in_b", ifc.input_b, b);
                check("z_ack", 64'(ifc.output_z_ack), 64'(mode == 0 && k == kz));
                check("res_valid", 64'(res_valid), 64'(mode == 0 && k > kz));
                check("op_ready_busy", 64'(op_ready), 64'(0));
                if (mode == 0 && k > kz) begin
                    check("res_z", res_z, z);
                    check("res_a", res_a, a);
                    check("res_b", res_b, b);
                end
            end else begin
                model_cnt++;
                check("res_valid_drop", 64'(res_valid), 64'(0));
                check("op_ready_back", 64'(op_ready), 64'(1));
                check("txn_count", 64'(txn_count), 64'(model_cnt % c_cnt_mod));
                done = 1'b1;
            end
            if (!done) begin
                ifc.input_a_ack  = (k == da);
                ifc.input_b_ack  = (mode != 1) && (k == db);
                ifc.output_z_stb = (mode == 0) && (k >= s + dz) && (k < kz);
                ifc.output_z     = z;
                res_ready        = (mode == 0) && (k == kr);
                @(posedge clk); #1;
                k++;
            end
        end
        idle_drive();
        check("txn_bounded", 64'(done), 64'(1));
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        idle_drive();
        clr_err = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready", 64'(op_ready), 64'(1));
        check("rst_stb_a", 64'(ifc.input_a_stb), 64'(0));
        check("rst_stb_b", 64'(ifc.input_b_stb), 64'(0));
        check("rst_z_ack", 64'(ifc.output_z_ack), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_err", 64'(err_timeout), 64'(0));
        check("rst_count", 64'(txn_count), 64'(0));
        check("rst_input_a", ifc.input_a, 64'(0));
        check("rst_res_z", res_z, 64'(0));
        rst_n = 1'b1;

        // 1.0 + 2.0
        run_txn(64'h3FF0000000000000, 64'h4000000000000000, 0, 0, 0, 0, 0);
        check("basic_sum", res_z, 64'h4008000000000000);
        check("basic_count", 64'(txn_count), 64'(1));

        // Split acks, then backpressure
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 3, 7, 2, 0, 0);
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 7, 3, 0, 20, 0);
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 2, 2, 4, 1, 0);

        // Watchdog in SEND; the flag must survive a good transaction
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 2, 0, 0, 0, 1);
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 1, 0, 0);
        check("err_sticky", 64'(err_timeout), 64'(1));
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("err_cleared", 64'(err_timeout), 64'(0));

        // Watchdog in WAIT_Z with clr_err held: set must win
        clr_err = 1'b1;
        run_txn({$urandom, $urandom}, {$urandom, $urandom}, 1, 4, 0, 0, 2);
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("err_clr_after", 64'(err_timeout), 64'(0));

        for (int i = 0; i < 20; i++) begin
            run_txn({$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 5)), 0);
        end

        // Asynchronous reset while output_z_ack is high
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        @(negedge clk);
        op_valid = 1'b1; op_a = ra; op_b = rb;
        @(posedge clk); #1;
        op_valid = 1'b0;
        ifc.input_a_ack = 1'b1; ifc.input_b_ack = 1'b1;
        @(posedge clk); #1;
        ifc.input_a_ack = 1'b0; ifc.input_b_ack = 1'b0;
        ifc.output_z_stb = 1'b1;
        @(posedge clk); #1;
        ifc.output_z_stb = 1'b0;
        check("pre_rst_z_ack", 64'(ifc.output_z_ack), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_z_ack", 64'(ifc.output_z_ack), 64'(0));
        check("arst_stb_a", 64'(ifc.input_a_stb), 64'(0));
        check("arst_res_valid", 64'(res_valid), 64'(0));
        check("arst_count", 64'(txn_count), 64'(0));
        check("arst_idle", 64'(op_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;

        // Asynchronous reset while strobes are high
        @(negedge clk);
        op_valid = 1'b1; op_a = ra; op_b = rb;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("pre_rst_stb_b", 64'(ifc.input_b_stb), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_send_stb_a", 64'(ifc.input_a_stb), 64'(0));
        check("arst_send_stb_b", 64'(ifc.input_b_stb), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap: 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            run_txn({$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 0, 0, 0);
        end
        check("wrap_final", 64'(txn_count), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no summary expected summary before 1ms");
        $fatal(1, "bench time limit reached");
    end

endmodule

`default_nettype wire
